// File: rtl/nios_fprint_sys_id_checker.sv
// nios_fprint_sys_id_checker
//   Reads the two words of an Avalon-MM system-ID slave (address 0: ID,
//   address 1: build timestamp) and compares them against the values this
//   build was generated with. One check sequence runs per accepted start.
//
// Ports
//   clock            in   sole clock, rising edge
//   reset            in   synchronous, active-high
//   start            in   one-cycle request, honoured only while idle
//   busy             out  sequence in progress (drops the cycle after done)
//   done             out  one-cycle pulse ending a sequence
//   id_ok / ts_ok    out  captured word equals the expected word
//   timeout          out  sequence aborted on a waitrequest stall timeout
//   id_value         out  captured address-0 word
//   ts_value         out  captured address-1 word
//   avm_address      out  word address to the slave
//   avm_read         out  read strobe
//   avm_readdata     in   read data
//   avm_waitrequest  in   slave stall
module nios_fprint_sys_id_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1442005037,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        FIN
    } state_t;

    // Last stalled cycle allowed: the abort happens on the TIMEOUT_CYCLES-th stall.
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_N      = 2'(READ_LATENCY);
    localparam bit          HAS_LAT    = (READ_LATENCY != 0);

    state_t      state_q, state_d;
    logic [15:0] stall_q, stall_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        lat_d       = lat_q;
        id_value_d  = id_value_q;
        ts_value_d  = ts_value_q;
        id_ok_d     = id_ok_q;
        ts_ok_d     = ts_ok_q;
        timeout_d   = timeout_q;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RD_ID;
                    stall_d    = '0;
                    lat_d      = '0;
                    id_value_d = '0;
                    ts_value_d = '0;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    timeout_d  = 1'b0;
                end
            end

            RD_ID: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    if (HAS_LAT) begin
                        state_d = LAT_ID;
                        lat_d   = 2'd1;
                    end else begin
                        // Zero-latency slave: data is valid in the acceptance cycle.
                        id_value_d = avm_readdata;
                        id_ok_d    = (avm_readdata == EXPECTED_ID);
                        state_d    = RD_TS;
                        stall_d    = '0;
                    end
                end else if (stall_q == STALL_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end

            LAT_ID: begin
                if (lat_q == LAT_N) begin
                    id_value_d = avm_readdata;
                    id_ok_d    = (avm_readdata == EXPECTED_ID);
                    state_d    = RD_TS;
                    stall_d    = '0;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (!avm_waitrequest) begin
                    if (HAS_LAT) begin
                        state_d = LAT_TS;
                        lat_d   = 2'd1;
                    end else begin
                        ts_value_d = avm_readdata;
                        ts_ok_d    = (avm_readdata == EXPECTED_TS);
                        state_d    = FIN;
                    end
                end else if (stall_q == STALL_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end

            LAT_TS: begin
                if (lat_q == LAT_N) begin
                    ts_value_d = avm_readdata;
                    ts_ok_d    = (avm_readdata == EXPECTED_TS);
                    state_d    = FIN;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            stall_q    <= '0;
            lat_q      <= '0;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            lat_q      <= lat_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign timeout  = timeout_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;

endmodule

// File: tb/tb_nios_fprint_sys_id_checker.sv
// Self-checking bench: u0 default parameters, u1 short stall timeout,
// u2 two-cycle read latency with a non-zero expected ID.
module tb_nios_fprint_sys_id_checker;

    localparam logic [31:0] DEF_TS = 32'd1442005037;
    localparam logic [31:0] U2_ID  = 32'hC0DE_0042;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] idv;
        logic [31:0] tsv;
        logic        idok;
        logic        tsok;
        logic        to;
    } result_t;

    logic        clk;
    logic        reset;
    logic        start_s [3];
    logic        wr_s    [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic        idok_s  [3];
    logic        tsok_s  [3];
    logic        to_s    [3];
    logic [31:0] idv_s   [3];
    logic [31:0] tsv_s   [3];
    logic        addr_s  [3];
    logic        rd_s    [3];
    logic [31:0] rdata_s [3];
    logic [31:0] mem_id  [3];
    logic [31:0] mem_ts  [3];
    logic [1:0]  pipe2   [2];

    result_t exp_q [3][$];
    int      ndone [3];
    int      checks;
    int      failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nios_fprint_sys_id_checker u0 (
        .clock(clk), .reset(reset), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .id_ok(idok_s[0]), .ts_ok(tsok_s[0]), .timeout(to_s[0]), .id_value(idv_s[0]),
        .ts_value(tsv_s[0]), .avm_address(addr_s[0]), .avm_read(rd_s[0]),
        .avm_readdata(rdata_s[0]), .avm_waitrequest(wr_s[0]));

    nios_fprint_sys_id_checker #(.TIMEOUT_CYCLES(4)) u1 (
        .clock(clk), .reset(reset), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .id_ok(idok_s[1]), .ts_ok(tsok_s[1]), .timeout(to_s[1]), .id_value(idv_s[1]),
        .ts_value(tsv_s[1]), .avm_address(addr_s[1]), .avm_read(rd_s[1]),
        .avm_readdata(rdata_s[1]), .avm_waitrequest(wr_s[1]));

    nios_fprint_sys_id_checker #(.EXPECTED_ID(U2_ID), .READ_LATENCY(2)) u2 (
        .clock(clk), .reset(reset), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .id_ok(idok_s[2]), .ts_ok(tsok_s[2]), .timeout(to_s[2]), .id_value(idv_s[2]),
        .ts_value(tsv_s[2]), .avm_address(addr_s[2]), .avm_read(rd_s[2]),
        .avm_readdata(rdata_s[2]), .avm_waitrequest(wr_s[2]));

    // Zero-latency slaves for u0/u1; u2's slave returns data exactly two cycles
    // after acceptance and junk at any other time.
    assign rdata_s[0] = addr_s[0] ? mem_ts[0] : mem_id[0];
    assign rdata_s[1] = addr_s[1] ? mem_ts[1] : mem_id[1];
    always @(posedge clk) begin
        pipe2[0] <= {rd_s[2] & ~wr_s[2], addr_s[2]};
        pipe2[1] <= pipe2[0];
    end
    assign rdata_s[2] = pipe2[1][1] ? (pipe2[1][0] ? mem_ts[2] : mem_id[2]) : JUNK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input int k, input string ph);
        chk($sformatf("u%0d %s busy", k, ph), 32'(busy_s[k]), 0);
        chk($sformatf("u%0d %s done", k, ph), 32'(done_s[k]), 0);
        chk($sformatf("u%0d %s id_ok", k, ph), 32'(idok_s[k]), 0);
        chk($sformatf("u%0d %s ts_ok", k, ph), 32'(tsok_s[k]), 0);
        chk($sformatf("u%0d %s timeout", k, ph), 32'(to_s[k]), 0);
        chk($sformatf("u%0d %s id_value", k, ph), idv_s[k], 0);
        chk($sformatf("u%0d %s ts_value", k, ph), tsv_s[k], 0);
        chk($sformatf("u%0d %s avm_read", k, ph), 32'(rd_s[k]), 0);
        chk($sformatf("u%0d %s avm_address", k, ph), 32'(addr_s[k]), 0);
    endtask

    // Scoreboard: every done pops the expectation pushed when start was driven.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_s[k] === 1'b1) begin
                result_t e;
                ndone[k]++;
                chk($sformatf("u%0d done has pending start", k), 32'(exp_q[k].size() != 0), 1);
                if (exp_q[k].size() != 0) begin
                    e = exp_q[k].pop_front();
                    chk($sformatf("u%0d id_value", k), idv_s[k], e.idv);
                    chk($sformatf("u%0d ts_value", k), tsv_s[k], e.tsv);
                    chk($sformatf("u%0d id_ok", k), 32'(idok_s[k]), 32'(e.idok));
                    chk($sformatf("u%0d ts_ok", k), 32'(tsok_s[k]), 32'(e.tsok));
                    chk($sformatf("u%0d timeout", k), 32'(to_s[k]), 32'(e.to));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        int nd;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            wr_s[k]    = 1'b0;
            ndone[k]   = 0;
            mem_ts[k]  = DEF_TS;
            mem_id[k]  = 32'd0;
        end
        mem_id[2] = U2_ID;
        repeat (3) step();
        for (int k = 0; k < 3; k++) chk_zero(k, "reset");
        reset = 1'b0;
        step();

        // Stall-free default sequence, cycle by cycle.
        start_s[0] = 1'b1;
        exp_q[0].push_back('{32'd0, DEF_TS, 1'b1, 1'b1, 1'b0});
        step();
        start_s[0] = 1'b0;
        chk("c1 avm_read", 32'(rd_s[0]), 1);
        chk("c1 avm_address", 32'(addr_s[0]), 0);
        chk("c1 busy", 32'(busy_s[0]), 1);
        step();
        chk("c2 avm_read", 32'(rd_s[0]), 1);
        chk("c2 avm_address", 32'(addr_s[0]), 1);
        chk("c2 id_ok early", 32'(idok_s[0]), 1);
        step();
        chk("c3 done", 32'(done_s[0]), 1);
        chk("c3 avm_read", 32'(rd_s[0]), 0);
        chk("c3 ts_ok", 32'(tsok_s[0]), 1);
        step();
        chk("c4 busy", 32'(busy_s[0]), 0);
        chk("c4 done", 32'(done_s[0]), 0);
        chk("c4 ts_ok held", 32'(tsok_s[0]), 1);

        // Wrong ID word.
        mem_id[0]  = 32'h0000_0001;
        start_s[0] = 1'b1;
        exp_q[0].push_back('{32'd1, DEF_TS, 1'b0, 1'b1, 1'b0});
        step();
        start_s[0] = 1'b0;
        repeat (5) step();
        chk("wrong id drained", 32'(exp_q[0].size()), 0);
        mem_id[0] = 32'd0;

        // start held while busy: one sequence only.
        nd = ndone[0];
        start_s[0] = 1'b1;
        exp_q[0].push_back('{32'd0, DEF_TS, 1'b1, 1'b1, 1'b0});
        repeat (2) step();
        start_s[0] = 1'b0;
        repeat (5) step();
        chk("start while busy done count", 32'(ndone[0] - nd), 1);

        // start together with reset is ignored.
        nd = ndone[0];
        reset = 1'b1;
        start_s[0] = 1'b1;
        step();
        reset = 1'b0;
        start_s[0] = 1'b0;
        chk("start+reset busy", 32'(busy_s[0]), 0);
        repeat (4) step();
        chk("start+reset done count", 32'(ndone[0] - nd), 0);

        // Reset during RD_TS, then a clean run.
        nd = ndone[0];
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        step();
        chk("in RD_TS address", 32'(addr_s[0]), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_zero(0, "abort RD_TS");
        start_s[0] = 1'b1;
        exp_q[0].push_back('{32'd0, DEF_TS, 1'b1, 1'b1, 1'b0});
        step();
        start_s[0] = 1'b0;
        repeat (5) step();
        chk("after abort done count", 32'(ndone[0] - nd), 1);

        // Stall timeout on u1.
        wr_s[1]    = 1'b1;
        start_s[1] = 1'b1;
        exp_q[1].push_back('{32'd0, 32'd0, 1'b0, 1'b0, 1'b1});
        step();
        start_s[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to stall%0d avm_read", i), 32'(rd_s[1]), 1);
            chk($sformatf("to stall%0d avm_address", i), 32'(addr_s[1]), 0);
            step();
        end
        chk("to done", 32'(done_s[1]), 1);
        chk("to avm_read dropped", 32'(rd_s[1]), 0);
        chk("to timeout", 32'(to_s[1]), 1);
        step();
        chk("to busy", 32'(busy_s[1]), 0);
        wr_s[1] = 1'b0;

        // Latency 2 with three stalled cycles on the ID read.
        nd = ndone[2];
        wr_s[2]    = 1'b1;
        start_s[2] = 1'b1;
        exp_q[2].push_back('{U2_ID, DEF_TS, 1'b1, 1'b1, 1'b0});
        step();
        start_s[2] = 1'b0;
        repeat (3) step();
        chk("lat still reading", 32'(rd_s[2]), 1);
        wr_s[2] = 1'b0;
        repeat (10) step();
        chk("lat done count", 32'(ndone[2] - nd), 1);

        // Reset during LAT_TS, then a clean run.
        nd = ndone[2];
        start_s[2] = 1'b1;
        step();
        start_s[2] = 1'b0;
        for (int i = 0; i < 10 && !(rd_s[2] && addr_s[2]); i++) step();
        chk("reached RD_TS", 32'(rd_s[2] & addr_s[2]), 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_zero(2, "abort LAT_TS");
        start_s[2] = 1'b1;
        exp_q[2].push_back('{U2_ID, DEF_TS, 1'b1, 1'b1, 1'b0});
        step();
        start_s[2] = 1'b0;
        repeat (12) step();
        chk("lat after abort done count", 32'(ndone[2] - nd), 1);

        for (int k = 0; k < 3; k++)
            chk($sformatf("u%0d queue empty", k), 32'(exp_q[k].size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
